// File: rtl/ctrl_decode_cs_stage.sv
// ctrl_decode_cs_stage
//   Registered ID-stage main decoder. Turns a 32-bit instruction into an
//   ID/EX control word one cycle later, with stall (hold) and flush (NOP).
//   The cache-switch opcode runs a small sequencer instead of producing a
//   control word. The sequencer drains memory, then handshakes the target
//   bank ID with the cache controller, with a timeout.
//
//   Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//     defined   : an undecoded opcode, or a switch to a non-existent bank,
//                 pulses illegal_instr and produces a NOP control word.
//     undefined : illegal_instr is tied to 0 and the default decode applies.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   instr, instr_valid    instruction from IF/ID and its valid flag
//   stall_in, flush       hold / clear the control register
//   mem_busy, cs_ack      memory-outstanding flag, cache controller ack
//   ctrl_valid .. alu_op  registered ID/EX control word
//   stall_out             freezes IF/ID while a switch is in progress
//   cs_req, cs_id         switch request and target bank
//   cur_cache             currently active bank
//   cs_done, cs_err       success pulse, sticky timeout error
//   illegal_instr         illegal-instruction pulse (optional feature)
module ctrl_decode_cs_stage #(
  parameter int         NUM_CACHES    = 4,
  parameter int         ID_W          = $clog2(NUM_CACHES),
  parameter logic [6:0] SWITCH_OPCODE = 7'b1111111,
  parameter int         TIMEOUT_CYC   = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instr,
  input  logic            instr_valid,
  input  logic            stall_in,
  input  logic            flush,
  input  logic            mem_busy,
  input  logic            cs_ack,
  output logic            ctrl_valid,
  output logic            d_mem_r,
  output logic            d_mem_w,
  output logic            jump,
  output logic            branch,
  output logic            wrten_reg,
  output logic            mux_complmnt,
  output logic            mux_d_mem,
  output logic            mux_inp_1,
  output logic            mux_inp_2,
  output logic [1:0]      mux_result,
  output logic [2:0]      mux_wire_module,
  output logic [2:0]      alu_op,
  output logic            stall_out,
  output logic            cs_req,
  output logic [ID_W-1:0] cs_id,
  output logic [ID_W-1:0] cur_cache,
  output logic            cs_done,
  output logic            cs_err,
  output logic            illegal_instr
);

  typedef struct packed {
    logic       ctrl_valid;
    logic       d_mem_r;
    logic       d_mem_w;
    logic       jump;
    logic       branch;
    logic       wrten_reg;
    logic       mux_complmnt;
    logic       mux_d_mem;
    logic       mux_inp_1;
    logic       mux_inp_2;
    logic [1:0] mux_result;
    logic [2:0] mux_wire_module;
    logic [2:0] alu_op;
  } ctrl_t;

  typedef enum logic [1:0] {IDLE, DRAIN, REQ, DONE} state_t;

  localparam ctrl_t          NOP       = '0;
  localparam logic [ID_W:0]  NC_W      = (ID_W+1)'(NUM_CACHES);
  localparam logic [7:0]     CNT_LAST  = 8'(TIMEOUT_CYC - 1);

  logic [6:0]      opcode;
  logic [2:0]      fun_3;
  logic [6:0]      fun_7;
  logic [ID_W-1:0] sw_target;
  logic            is_switch;
  logic            sw_in_range;
  logic            accept;
  logic            sw_start;
  logic            known_op;
  logic            dec_illegal;
  ctrl_t           dec_word;
  ctrl_t           ctrl_reg;
  logic            illegal_reg;
  state_t          state_reg;
  logic [7:0]      cnt_reg;
  logic            stall_reg;
  logic            cs_req_reg;
  logic            cs_done_reg;
  logic            cs_err_reg;
  logic [ID_W-1:0] cs_id_reg;
  logic [ID_W-1:0] cur_cache_reg;

  assign opcode      = instr[6:0];
  assign fun_3       = instr[14:12];
  assign fun_7       = instr[31:25];
  assign sw_target   = instr[20+ID_W-1:20];
  assign is_switch   = (opcode == SWITCH_OPCODE);
  assign sw_in_range = ({1'b0, sw_target} < NC_W);
  assign accept      = instr_valid && !stall_reg && !stall_in;
  // A flushed instruction is squashed, so it cannot start a switch either.
  assign sw_start    = accept && !flush && is_switch && sw_in_range &&
                       (sw_target != cur_cache_reg);

  // Combinational decode of the instruction currently in IF/ID.
  always_comb begin
    dec_word             = NOP;
    dec_word.ctrl_valid  = 1'b1;
    dec_word.alu_op      = fun_3;
    known_op             = 1'b1;
    case (opcode)
      7'b0110111: begin // LUI
        dec_word.wrten_reg = 1'b1; dec_word.mux_d_mem = 1'b1; dec_word.mux_result = 2'd1;
        dec_word.mux_inp_2 = 1'b1; dec_word.mux_wire_module = 3'd3; dec_word.alu_op = 3'd0;
      end
      7'b0010111: begin // AUIPC
        dec_word.wrten_reg = 1'b1; dec_word.mux_d_mem = 1'b1; dec_word.mux_result = 2'd2;
        dec_word.mux_inp_2 = 1'b1; dec_word.mux_inp_1 = 1'b1; dec_word.mux_wire_module = 3'd3;
        dec_word.alu_op = 3'd0;
      end
      7'b1101111: begin // JAL
        dec_word.wrten_reg = 1'b1; dec_word.mux_d_mem = 1'b1; dec_word.mux_result = 2'd3;
        dec_word.mux_inp_2 = 1'b1; dec_word.mux_inp_1 = 1'b1; dec_word.mux_wire_module = 3'd1;
        dec_word.alu_op = 3'd0; dec_word.jump = 1'b1;
      end
      7'b1100111: begin // JALR
        dec_word.wrten_reg = 1'b1; dec_word.mux_d_mem = 1'b1; dec_word.mux_result = 2'd3;
        dec_word.mux_inp_2 = 1'b1; dec_word.mux_wire_module = 3'd4; dec_word.alu_op = 3'd0;
        dec_word.jump = 1'b1;
      end
      7'b1100011: begin // BRANCH
        dec_word.mux_complmnt = 1'b1; dec_word.alu_op = 3'd0; dec_word.branch = 1'b1;
      end
      7'b0000011: begin // LOAD
        dec_word.wrten_reg = 1'b1; dec_word.mux_result = 2'd2; dec_word.mux_inp_2 = 1'b1;
        dec_word.mux_wire_module = 3'd4; dec_word.alu_op = 3'd0; dec_word.d_mem_r = 1'b1;
      end
      7'b0100011: begin // STORE
        dec_word.mux_result = 2'd2; dec_word.mux_inp_2 = 1'b1; dec_word.mux_wire_module = 3'd2;
        dec_word.alu_op = 3'd0; dec_word.d_mem_w = 1'b1;
      end
      7'b0010011: begin // OP-IMM
        dec_word.wrten_reg = 1'b1; dec_word.mux_d_mem = 1'b1; dec_word.mux_result = 2'd2;
        dec_word.mux_inp_2 = 1'b1; dec_word.mux_wire_module = 3'd4;
      end
      7'b0110011: begin // OP
        dec_word.wrten_reg = 1'b1; dec_word.mux_complmnt = fun_7[5];
        dec_word.mux_d_mem = 1'b1; dec_word.mux_result = 2'd2;
      end
      default: known_op = 1'b0;
    endcase
`ifdef CTRL_ILLEGAL_TRAP_EN
    dec_illegal = is_switch ? !sw_in_range : !known_op;
    if (!known_op)
      dec_word = NOP;
`else
    dec_illegal = 1'b0;
`endif
    // The switch never reaches EX; the sequencer handles it instead.
    if (is_switch)
      dec_word = NOP;
  end

  // ID/EX control register: flush beats stall, idle cycles load NOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg    <= NOP;
      illegal_reg <= 1'b0;
    end else if (flush) begin
      ctrl_reg    <= NOP;
      illegal_reg <= 1'b0;
    end else if (stall_in) begin
      illegal_reg <= 1'b0;
    end else if (accept) begin
      ctrl_reg    <= dec_word;
      illegal_reg <= dec_illegal;
    end else begin
      ctrl_reg    <= NOP;
      illegal_reg <= 1'b0;
    end
  end

  // Cache-switch sequencer; all its outputs are registered alongside state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      stall_reg     <= 1'b0;
      cs_req_reg    <= 1'b0;
      cs_done_reg   <= 1'b0;
      cs_err_reg    <= 1'b0;
      cs_id_reg     <= '0;
      cur_cache_reg <= '0;
    end else begin
      cs_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sw_start) begin
            state_reg <= DRAIN;
            cs_id_reg <= sw_target;
            stall_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            state_reg  <= REQ;
            cs_req_reg <= 1'b1;
          end
        end
        REQ: begin
          // Ack wins over a coincident timeout.
          if (cs_ack) begin
            state_reg     <= DONE;
            cs_req_reg    <= 1'b0;
            cs_done_reg   <= 1'b1;
            cur_cache_reg <= cs_id_reg;
            cnt_reg       <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg  <= IDLE;
            cs_req_reg <= 1'b0;
            stall_reg  <= 1'b0;
            cs_err_reg <= 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          stall_reg <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ctrl_valid      = ctrl_reg.ctrl_valid;
  assign d_mem_r         = ctrl_reg.d_mem_r;
  assign d_mem_w         = ctrl_reg.d_mem_w;
  assign jump            = ctrl_reg.jump;
  assign branch          = ctrl_reg.branch;
  assign wrten_reg       = ctrl_reg.wrten_reg;
  assign mux_complmnt    = ctrl_reg.mux_complmnt;
  assign mux_d_mem       = ctrl_reg.mux_d_mem;
  assign mux_inp_1       = ctrl_reg.mux_inp_1;
  assign mux_inp_2       = ctrl_reg.mux_inp_2;
  assign mux_result      = ctrl_reg.mux_result;
  assign mux_wire_module = ctrl_reg.mux_wire_module;
  assign alu_op          = ctrl_reg.alu_op;
  assign stall_out       = stall_reg;
  assign cs_req          = cs_req_reg;
  assign cs_id           = cs_id_reg;
  assign cur_cache       = cur_cache_reg;
  assign cs_done         = cs_done_reg;
  assign cs_err          = cs_err_reg;
  assign illegal_instr   = illegal_reg;

endmodule

// File: tb/tb_ctrl_decode_cs_stage.sv
// Testbench for ctrl_decode_cs_stage: table of decode vectors plus
// hand-written sequences for stall/flush, cache switch, timeout and reset.
module tb_ctrl_decode_cs_stage;

  localparam int ID_W = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     instr;
  logic            instr_valid, stall_in, flush, mem_busy, cs_ack;
  logic            ctrl_valid, d_mem_r, d_mem_w, jump, branch, wrten_reg;
  logic            mux_complmnt, mux_d_mem, mux_inp_1, mux_inp_2;
  logic [1:0]      mux_result;
  logic [2:0]      mux_wire_module, alu_op;
  logic            stall_out, cs_req, cs_done, cs_err, illegal_instr;
  logic [ID_W-1:0] cs_id, cur_cache;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  ctrl_decode_cs_stage #(
    .NUM_CACHES(4), .SWITCH_OPCODE(7'b1111111), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .stall_in(stall_in), .flush(flush), .mem_busy(mem_busy), .cs_ack(cs_ack),
    .ctrl_valid(ctrl_valid), .d_mem_r(d_mem_r), .d_mem_w(d_mem_w), .jump(jump),
    .branch(branch), .wrten_reg(wrten_reg), .mux_complmnt(mux_complmnt),
    .mux_d_mem(mux_d_mem), .mux_inp_1(mux_inp_1), .mux_inp_2(mux_inp_2),
    .mux_result(mux_result), .mux_wire_module(mux_wire_module), .alu_op(alu_op),
    .stall_out(stall_out), .cs_req(cs_req), .cs_id(cs_id), .cur_cache(cur_cache),
    .cs_done(cs_done), .cs_err(cs_err), .illegal_instr(illegal_instr)
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic [17:0] exp_ctrl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[16];

  // Expected control word, fields in a fixed bench-chosen order.
  function automatic logic [17:0] mk(input logic v, r, w, j, b, wr, cmp, dm, i1, i2,
                                     input logic [1:0] res, input logic [2:0] wm, alu);
    return {v, r, w, j, b, wr, cmp, dm, i1, i2, res, wm, alu};
  endfunction

  function automatic logic [17:0] act_ctrl();
    return {ctrl_valid, d_mem_r, d_mem_w, jump, branch, wrten_reg, mux_complmnt,
            mux_d_mem, mux_inp_1, mux_inp_2, mux_result, mux_wire_module, alu_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    instr = 32'h0; instr_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    mem_busy = 1'b0; cs_ack = 1'b0;
  endtask

  logic [17:0] lw_word;
  int          req_cnt;

  initial begin
    vecs[0]  = '{"add",    32'h003100B3, 1'b1, 1'b0, mk(1,0,0,0,0,1,0,1,0,0,2'd2,3'd0,3'd0), 1'b0};
    vecs[1]  = '{"sub",    32'h403100B3, 1'b1, 1'b0, mk(1,0,0,0,0,1,1,1,0,0,2'd2,3'd0,3'd0), 1'b0};
    vecs[2]  = '{"lui",    32'h000010B7, 1'b1, 1'b0, mk(1,0,0,0,0,1,0,1,0,1,2'd1,3'd3,3'd0), 1'b0};
    vecs[3]  = '{"auipc",  32'h00001097, 1'b1, 1'b0, mk(1,0,0,0,0,1,0,1,1,1,2'd2,3'd3,3'd0), 1'b0};
    vecs[4]  = '{"jal",    32'h008000EF, 1'b1, 1'b0, mk(1,0,0,1,0,1,0,1,1,1,2'd3,3'd1,3'd0), 1'b0};
    vecs[5]  = '{"jalr",   32'h000080E7, 1'b1, 1'b0, mk(1,0,0,1,0,1,0,1,0,1,2'd3,3'd4,3'd0), 1'b0};
    vecs[6]  = '{"bne",    32'h00209463, 1'b1, 1'b0, mk(1,0,0,0,1,0,1,0,0,0,2'd0,3'd0,3'd0), 1'b0};
    vecs[7]  = '{"lw",     32'h00012083, 1'b1, 1'b0, mk(1,1,0,0,0,1,0,0,0,1,2'd2,3'd4,3'd0), 1'b0};
    vecs[8]  = '{"sw",     32'h00112223, 1'b1, 1'b0, mk(1,0,1,0,0,0,0,0,0,1,2'd2,3'd2,3'd0), 1'b0};
    vecs[9]  = '{"andi",   32'h0070F093, 1'b1, 1'b0, mk(1,0,0,0,0,1,0,1,0,1,2'd2,3'd4,3'd7), 1'b0};
    vecs[10] = '{"xor",    32'h0031C0B3, 1'b1, 1'b0, mk(1,0,0,0,0,1,0,1,0,0,2'd2,3'd0,3'd4), 1'b0};
    vecs[11] = '{"novalid",32'h003100B3, 1'b0, 1'b0, 18'h0, 1'b0};
    vecs[12] = '{"flush",  32'h003100B3, 1'b1, 1'b1, 18'h0, 1'b0};
`ifdef CTRL_ILLEGAL_TRAP_EN
    vecs[13] = '{"custom", 32'h0000500B, 1'b1, 1'b0, 18'h0, 1'b1};
`else
    vecs[13] = '{"custom", 32'h0000500B, 1'b1, 1'b0, mk(1,0,0,0,0,0,0,0,0,0,2'd0,3'd0,3'd5), 1'b0};
`endif
    vecs[14] = '{"sw_same",32'h0000007F, 1'b1, 1'b0, 18'h0, 1'b0};
    vecs[15] = '{"add2",   32'h003100B3, 1'b1, 1'b0, mk(1,0,0,0,0,1,0,1,0,0,2'd2,3'd0,3'd0), 1'b0};
    lw_word  = vecs[7].exp_ctrl;

    // Reset state
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    chk("reset_ctrl", {14'h0, act_ctrl()}, 32'h0);
    chk("reset_fsm", {25'h0, stall_out, cs_req, cs_id, cur_cache, cs_done, cs_err, illegal_instr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table-driven decode vectors
    for (int i = 0; i < 16; i++) begin
      instr = vecs[i].instr; instr_valid = vecs[i].valid; flush = vecs[i].flush;
      tick();
      chk({vecs[i].name, "_ctrl"}, {14'h0, act_ctrl()}, {14'h0, vecs[i].exp_ctrl});
      chk({vecs[i].name, "_ill"}, {31'h0, illegal_instr}, {31'h0, vecs[i].exp_ill});
      if (i == 14) chk("sw_same_stall", {31'h0, stall_out}, 32'h0);
    end
    idle_inputs();

    // LW then stall_in for 3 cycles, then flush during stall
    instr = 32'h00012083; instr_valid = 1'b1;
    tick();
    chk("lw_load", {14'h0, act_ctrl()}, {14'h0, lw_word});
    instr = 32'h003100B3; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lw_hold%0d", i), {14'h0, act_ctrl()}, {14'h0, lw_word});
    end
    flush = 1'b1;
    tick();
    chk("flush_over_stall", {14'h0, act_ctrl()}, 32'h0);
    idle_inputs();
    tick();

    // Switch to bank 2 with mem_busy held 4 cycles in DRAIN
    instr = 32'h0020007F; instr_valid = 1'b1; mem_busy = 1'b1;
    tick();
    chk("sw2_drain_stall", {30'h0, stall_out, cs_req}, 32'h2);
    chk("sw2_ctrl_nop", {31'h0, ctrl_valid}, 32'h0);
    chk("sw2_cs_id", {30'h0, cs_id}, 32'h2);
    instr = 32'h003100B3;
    for (int i = 0; i < 4; i++) begin
      cs_ack = (i == 1);  // ack outside REQ must be ignored
      tick();
      chk($sformatf("sw2_drain%0d", i), {30'h0, stall_out, cs_req}, 32'h2);
    end
    chk("sw2_blocked_instr", {31'h0, ctrl_valid}, 32'h0);
    cs_ack = 1'b0; mem_busy = 1'b0;
    tick();
    chk("sw2_req", {30'h0, stall_out, cs_req}, 32'h3);
    flush = 1'b1;  // flush does not abort the switch
    tick();
    chk("sw2_req_flush", {30'h0, stall_out, cs_req}, 32'h3);
    flush = 1'b0;
    tick();
    chk("sw2_req_hold", {31'h0, cs_req}, 32'h1);
    cs_ack = 1'b1;
    tick();
    cs_ack = 1'b0;
    chk("sw2_done", {28'h0, stall_out, cs_req, cs_done, cs_err}, 32'h0000000A);
    chk("sw2_cur", {30'h0, cur_cache}, 32'h2);
    tick();
    chk("sw2_after", {29'h0, stall_out, cs_done, cs_req}, 32'h0);
    chk("sw2_after_cur", {30'h0, cur_cache}, 32'h2);

    // Switch to bank 2 again while active bank is 2: no-op
    instr = 32'h0020007F; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("sw_same_noop", {30'h0, stall_out, cs_req}, 32'h0);
    tick();
    chk("sw_same_noop2", {30'h0, stall_out, cs_req}, 32'h0);

    // Switch to bank 1, never acked: timeout after 8 REQ cycles
    instr = 32'h0010007F; instr_valid = 1'b1;
    tick();
    idle_inputs();
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cs_req) req_cnt++;
      if (!stall_out) break;
    end
    chk("to_req_cycles", req_cnt, 8);
    chk("to_err_idle", {29'h0, cs_err, stall_out, cs_req}, 32'h4);
    chk("to_cur", {30'h0, cur_cache}, 32'h2);

    // Switch to bank 3, ack arrives in the same cycle as the timeout
    instr = 32'h0030007F; instr_valid = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("co_req", {31'h0, cs_req}, 32'h1);
    for (int i = 0; i < 7; i++) tick();
    chk("co_req_last", {31'h0, cs_req}, 32'h1);
    cs_ack = 1'b1;
    tick();
    cs_ack = 1'b0;
    chk("co_done", {31'h0, cs_done}, 32'h1);
    chk("co_cur", {30'h0, cur_cache}, 32'h3);
    tick();

    // Asynchronous reset mid-REQ
    instr = 32'h0000007F; instr_valid = 1'b1;
    tick();
    idle_inputs();
    tick();
    chk("ar_req", {31'h0, cs_req}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_fsm", {25'h0, stall_out, cs_req, cs_id, cur_cache, cs_done, cs_err, illegal_instr}, 32'h0);
    chk("ar_ctrl", {14'h0, act_ctrl()}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("ar_after", {30'h0, stall_out, cs_req}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_cs_stage.md
Name: ctrl_decode_cs_stage

Overview:
Registered successor of the combinational main decoder. It decodes a 32-bit instruction into a pipelined ID/EX control word with stall and flush support. The cache-switch opcode becomes a multi-cycle sequencer: it drains memory, then handshakes a bank ID to the cache controller with a timeout. It sits between IF/ID and ID/EX, and its stall_out feeds the hazard unit.

Parameters:
NUM_CACHES, 4, number of cache banks; must be ≥2.
ID_W, $clog2(NUM_CACHES), width of the bank ID.
SWITCH_OPCODE, 7'b1111111, opcode of the cache-switch instruction.
TIMEOUT_CYC, 255, maximum cycles in REQ before an error abort; 8-bit counter, range 1..255.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high.
instr  in  32  instruction; opcode=[6:0], fun_3=[14:12], fun_7=[31:25].
instr_valid  in  1  instr is valid this cycle.
stall_in  in  1  downstream stall; hold the control register.
flush  in  1  replace the control register with NOP.
mem_busy  in  1  data memory has outstanding accesses.
cs_ack  in  1  cache controller has completed the switch.
ctrl_valid  out  1  control word is valid.
d_mem_r, d_mem_w, jump, branch, wrten_reg, mux_complmnt, mux_d_mem, mux_inp_1, mux_inp_2  out  1 each  registered controls.
mux_result  out  2  registered result-mux select.
mux_wire_module  out  3  registered immediate-type select.
alu_op  out  3  registered ALU operation.
stall_out  out  1  freeze IF/ID.
cs_req  out  1  switch request to the cache controller.
cs_id  out  ID_W  target bank ID.
cur_cache  out  ID_W  currently active bank.
cs_done  out  1  one-cycle pulse on successful switch.
cs_err  out  1  sticky error flag; cleared only by reset.
illegal_instr  out  1  one-cycle pulse (optional feature).

Behaviour:
- Reset:
  - All outputs are 0; cur_cache=0.
  - FSM goes to IDLE and the timeout counter clears.
  - Reset asserted mid-switch drops cs_req immediately, asynchronously.
- Decode table. Columns: wrten_reg, mux_complmnt, mux_d_mem, mux_result, mux_inp_2, mux_inp_1, mux_wire_module, alu_op.
  - LUI 0110111: 1,0,1,1,1,0,3,0.
  - AUIPC 0010111: 1,0,1,2,1,1,3,0.
  - JAL 1101111: 1,0,1,3,1,1,1,0; jump=1.
  - JALR 1100111: 1,0,1,3,1,0,4,0; jump=1.
  - BRANCH 1100011: 0,1,0,0,0,0,0,0; branch=1.
  - LOAD 0000011: 1,0,0,2,1,0,4,0; d_mem_r=1.
  - STORE 0100011: 0,0,0,2,1,0,2,0; d_mem_w=1.
  - OP-IMM 0010011: 1,0,1,2,1,0,4,fun_3.
  - OP 0110011: 1,fun_7[5],1,2,0,0,0,fun_3.
  - Any control bit not listed for an opcode is 0.
  - Default (any other opcode): all controls 0, alu_op=fun_3.
- Latency and register control:
  - The control word appears 1 cycle after an accepted instr (instr_valid=1, stall_out=0, stall_in=0).
  - stall_in=1 holds the register.
  - flush=1 loads NOP (all controls 0, alu_op=0, ctrl_valid=0).
  - flush has priority over stall_in.
  - A cycle with no accepted instruction loads NOP.
- Switch instruction (opcode=SWITCH_OPCODE):
  - Target ID = instr[20+ID_W-1:20].
  - The control register always receives NOP for it.
  - If target == cur_cache, or target ≥ NUM_CACHES, it is a NOP and the FSM stays in IDLE.
  - Otherwise the FSM goes IDLE→DRAIN and latches cs_id.
- FSM:
  - IDLE: stall_out=0.
  - DRAIN: stall_out=1. Stay while mem_busy=1; go to REQ when mem_busy=0.
  - REQ: cs_req=1, stall_out=1, counter increments each cycle.
    - cs_ack=1 → DONE and clear the counter.
    - Counter reaches TIMEOUT_CYC without ack → IDLE, set cs_err=1, cur_cache unchanged.
  - DONE: single cycle. cs_done=1, cur_cache←cs_id, stall_out=1, then → IDLE.
- Handshake rules:
  - cs_req stays high until the cycle cs_ack is sampled.
  - cs_ack in the same cycle as a timeout counts as success.
  - cs_ack outside REQ is ignored.
  - flush while the FSM is busy does not abort the switch.

Optional Feature:
CTRL_ILLEGAL_TRAP_EN.
- Defined: an accepted instruction with an undecoded opcode, or a switch with target ≥ NUM_CACHES, pulses illegal_instr for 1 cycle, aligned with the control word. Its control word is NOP.
- Undefined: illegal_instr is tied to 0 and the default decode applies.

Test Plan:
- Reset, then ADD x1,x2,x3 (0x003100B3) valid → next cycle: wrten_reg=1, mux_result=2, mux_d_mem=1, alu_op=0, mux_complmnt=0; SUB (fun_7=0100000) → mux_complmnt=1.
- LW followed by stall_in=1 for 3 cycles → d_mem_r=1, mux_wire_module=4 held for 3 cycles; flush during the stall → all controls 0, ctrl_valid=0.
- Switch to ID 2 with mem_busy=1 for 4 cycles → stall_out high, cs_req rises in cycle 6, cs_ack after 3 cycles → cs_done pulse, cur_cache=2, stall_out low the following cycle.
- Switch to ID 2 while cur_cache=2 → no cs_req, stall_out stays 0.
- Switch with cs_ack never asserted, TIMEOUT_CYC=8 → cs_req high for 8 cycles, then cs_err=1, cur_cache unchanged, FSM in IDLE.
- With CTRL_ILLEGAL_TRAP_EN defined: opcode 0001011 → illegal_instr pulse, NOP control word; assert reset mid-REQ → cs_req=0 immediately, all outputs 0.
